fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_pc_reg.sv | 27 ++
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encodings, reset PC default
// and small address helpers.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_KILL  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, loads din when load=1.
module pc_reg
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] din,
  output logic [31:0] q
);

  logic [31:0] pc_r;

  // PC storage with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= din;
    end
  end

  assign q = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect, stall and a
// sticky misaligned-target error state.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [2:0]  state_r;
  logic        imem_req_r;
  logic        inst_valid_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic        misalign_err_r;
  logic [31:0] fetch_count_r;

  logic [31:0] pc_q_s;
  logic [31:0] pc_plus4_s;
  logic        accept_s;
  logic        redirect_act_s;
  logic        target_ok_s;

  logic [2:0]  base_next_s;
  logic        base_load_s;
  logic        base_capture_s;
  logic        base_consume_s;

  logic [2:0]  next_state_s;
  logic        pc_load_s;
  logic [31:0] pc_din_s;
  logic        capture_s;
  logic        consume_s;
  logic        misalign_set_s;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock (clock),
    .reset (reset),
    .load  (pc_load_s),
    .din   (pc_din_s),
    .q     (pc_q_s)
  );

  assign pc_plus4_s     = pc_q_s + PC_STEP;
  // imem_req_r is high exactly when state_r is FETCH, so this is the handshake
  assign accept_s       = (state_r == ST_FETCH) && imem_ready;
  assign redirect_act_s = redirect && (state_r != ST_ERR);
  assign target_ok_s    = is_word_aligned(redirect_pc);

  // Normal FSM progression, ignoring redirect
  always_comb begin
    base_next_s    = state_r;
    base_load_s    = 1'b0;
    base_capture_s = 1'b0;
    base_consume_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (accept_s) begin
          base_next_s = ST_WAIT;
        end else begin
          base_next_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          base_capture_s = 1'b1;
          base_next_s    = ST_HOLD;
        end else begin
          base_next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          base_consume_s = 1'b1;
          base_load_s    = 1'b1;
          base_next_s    = ST_FETCH;
        end else begin
          base_next_s = ST_HOLD;
        end
      end
      ST_KILL: begin
        if (imem_rvalid) begin
          base_next_s = ST_FETCH;
        end else begin
          base_next_s = ST_KILL;
        end
      end
      ST_ERR: begin
        base_next_s = ST_ERR;
      end
      default: begin
        base_next_s = ST_FETCH;
      end
    endcase
  end

  // Redirect overrides the normal progression; a pending response forces KILL
  always_comb begin
    next_state_s   = base_next_s;
    pc_load_s      = base_load_s;
    pc_din_s       = pc_plus4_s;
    capture_s      = base_capture_s;
    consume_s      = base_consume_s;
    misalign_set_s = 1'b0;
    if (redirect_act_s) begin
      capture_s = 1'b0;
      consume_s = 1'b0;
      if (!target_ok_s) begin
        next_state_s   = ST_ERR;
        pc_load_s      = 1'b0;
        misalign_set_s = 1'b1;
      end else begin
        pc_load_s = 1'b1;
        pc_din_s  = redirect_pc;
        if ((state_r == ST_WAIT) || (state_r == ST_KILL) || accept_s) begin
          next_state_s = ST_KILL;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
    end else begin
      pc_din_s = pc_plus4_s;
    end
  end

  // State and output registers; outputs are decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_FETCH;
      imem_req_r     <= 1'b1;
      inst_valid_r   <= 1'b0;
      inst_r         <= 32'h0000_0000;
      inst_pc_r      <= 32'h0000_0000;
      misalign_err_r <= 1'b0;
      fetch_count_r  <= 32'h0000_0000;
    end else begin
      state_r      <= next_state_s;
      imem_req_r   <= (next_state_s == ST_FETCH);
      inst_valid_r <= (next_state_s == ST_HOLD);
      if (capture_s) begin
        inst_r    <= imem_rdata;
        inst_pc_r <= pc_q_s;
      end
      if (consume_s) begin
        fetch_count_r <= fetch_count_r + 32'h0000_0001;
      end
      if (misalign_set_s) begin
        misalign_err_r <= 1'b1;
      end
    end
  end

  assign imem_req     = imem_req_r;
  assign imem_addr    = pc_q_s;
  assign inst_valid   = inst_valid_r;
  assign inst         = inst_r;
  assign inst_pc      = inst_pc_r;
  assign misalign_err = misalign_err_r;
  assign fetch_count  = fetch_count_r;

endmodule
